// File: rtl/axi_pwm_capture_if.sv
// Four-channel PWM capture front-end.
// Each channel synchronizes its pwm_in bit and measures the high time and
// the period in pwm_clk cycles. Results are 12-bit words in the same encoding
// the 12-bit PWM generator consumes. A channel that sees no rising edge for
// TIMEOUT cycles reports a pinned level (4095 or 0) and raises stuck.

module axi_pwm_capture_if #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic        pwm_clk,
  input  logic        rst,
  input  logic [3:0]  pwm_in,
  output logic [11:0] data_channel_0,
  output logic [11:0] data_channel_1,
  output logic [11:0] data_channel_2,
  output logic [11:0] data_channel_3,
  output logic [11:0] period_channel_0,
  output logic [11:0] period_channel_1,
  output logic [11:0] period_channel_2,
  output logic [11:0] period_channel_3,
  output logic [3:0]  data_valid,
  output logic [3:0]  stuck
);

  localparam int                NCH       = 4;
  localparam int                DATA_W    = 12;
  localparam logic [DATA_W-1:0] CNT_MAX   = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] CNT_ONE   = DATA_W'(1);
  localparam logic [DATA_W-1:0] TIMEOUT_W = DATA_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_e;

  // Counters pin at full scale instead of wrapping, so an over-long period
  // can never alias to a short one.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  logic [NCH*DATA_W-1:0] data_flat;
  logic [NCH*DATA_W-1:0] period_flat;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   timeout;
    logic                   restart;
    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      period_cnt_q, period_cnt_d;
    logic [DATA_W-1:0]      high_cnt_q, high_cnt_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [DATA_W-1:0]      period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;

    // s is the settled input level; s_d_q is that level one cycle earlier.
    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign fall    = ~s & s_d_q;
    assign timeout = (period_cnt_q == TIMEOUT_W);

    // Metastability synchronizer followed by the edge-detect delay flop.
    always_ff @(posedge pwm_clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        s_d_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in[ch]};
        s_d_q  <= s;
      end
    end

    // Channel FSM: a rise always takes priority over a coincident timeout.
    always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      period_d = period_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
      restart  = rise;
      unique case (state_q)
        IDLE: begin
          // First edge after idle only opens a measurement window.
          if (rise) begin
            state_d = MEASURE;
          end else if (timeout) begin
            state_d  = STUCK;
            data_d   = s ? CNT_MAX : '0;
            period_d = CNT_MAX;
            valid_d  = 1'b1;
            stuck_d  = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            data_d   = high_cnt_q;
            period_d = period_cnt_q;
            valid_d  = 1'b1;
          end else if (timeout) begin
            state_d  = STUCK;
            data_d   = s ? CNT_MAX : '0;
            period_d = CNT_MAX;
            valid_d  = 1'b1;
            stuck_d  = 1'b1;
          end
        end
        STUCK: begin
          // Any level change leaves STUCK; a fall re-arms the timeout from
          // scratch so a constant low after stuck-high reports 0 later.
          if (rise) begin
            state_d = MEASURE;
            stuck_d = 1'b0;
          end else if (fall) begin
            state_d = IDLE;
            stuck_d = 1'b0;
            restart = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Period and high-time counters, restarted at every measurement boundary.
    always_comb begin
      period_cnt_d = sat_inc(period_cnt_q);
      high_cnt_d   = s ? sat_inc(high_cnt_q) : high_cnt_q;
      if (restart) begin
        period_cnt_d = CNT_ONE;
        high_cnt_d   = CNT_ONE;
      end
    end

    // Channel state, counters and captured output words.
    always_ff @(posedge pwm_clk or posedge rst) begin
      if (rst) begin
        state_q      <= IDLE;
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        data_q       <= '0;
        period_q     <= '0;
        valid_q      <= 1'b0;
        stuck_q      <= 1'b0;
      end else begin
        state_q      <= state_d;
        period_cnt_q <= period_cnt_d;
        high_cnt_q   <= high_cnt_d;
        data_q       <= data_d;
        period_q     <= period_d;
        valid_q      <= valid_d;
        stuck_q      <= stuck_d;
      end
    end

    assign data_flat[ch*DATA_W +: DATA_W]   = data_q;
    assign period_flat[ch*DATA_W +: DATA_W] = period_q;
    assign data_valid[ch]                   = valid_q;
    assign stuck[ch]                        = stuck_q;
  end

  assign data_channel_0   = data_flat[0*DATA_W +: DATA_W];
  assign data_channel_1   = data_flat[1*DATA_W +: DATA_W];
  assign data_channel_2   = data_flat[2*DATA_W +: DATA_W];
  assign data_channel_3   = data_flat[3*DATA_W +: DATA_W];
  assign period_channel_0 = period_flat[0*DATA_W +: DATA_W];
  assign period_channel_1 = period_flat[1*DATA_W +: DATA_W];
  assign period_channel_2 = period_flat[2*DATA_W +: DATA_W];
  assign period_channel_3 = period_flat[3*DATA_W +: DATA_W];

endmodule

// File: tb/tb_axi_pwm_capture_if.sv
// Bench for axi_pwm_capture_if. Inputs come from per-channel PWM generators
// with random periods, duties, phases and glitches. The reference model keeps
// the sampled input history and derives each measurement from it: the time
// since the last restart point and the number of high samples in that window.

module tb_axi_pwm_capture_if;

  localparam int NCH     = 4;
  localparam int SAT     = 4095;
  localparam int TO      = 4095;
  localparam int MAXN    = 32768;
  localparam int M_IDLE  = 0;
  localparam int M_MEAS  = 1;
  localparam int M_STUCK = 2;

  logic        pwm_clk = 1'b0;
  logic        rst     = 1'b0;
  logic [3:0]  pwm_in  = '0;
  logic [11:0] data_channel_0, data_channel_1, data_channel_2, data_channel_3;
  logic [11:0] period_channel_0, period_channel_1, period_channel_2, period_channel_3;
  logic [3:0]  data_valid;
  logic [3:0]  stuck;

  axi_pwm_capture_if #(
    .SYNC_STAGES(2),
    .TIMEOUT    (TO)
  ) dut (
    .pwm_clk         (pwm_clk),
    .rst             (rst),
    .pwm_in          (pwm_in),
    .data_channel_0  (data_channel_0),
    .data_channel_1  (data_channel_1),
    .data_channel_2  (data_channel_2),
    .data_channel_3  (data_channel_3),
    .period_channel_0(period_channel_0),
    .period_channel_1(period_channel_1),
    .period_channel_2(period_channel_2),
    .period_channel_3(period_channel_3),
    .data_valid      (data_valid),
    .stuck           (stuck)
  );

  always #5 pwm_clk = ~pwm_clk;

  int n_vec = 0;
  int n_err = 0;

  // Input generators: gp==0 means constant level glvl.
  int gp[NCH], gh[NCH], gph[NCH], glitch[NCH], glvl[NCH];

  // Reference model state.
  logic [3:0] xh [MAXN];
  int         n_edge;
  int         st[NCH];
  int         r[NCH];
  int         e_data[NCH];
  int         e_per[NCH];
  logic [3:0] e_valid;
  logic [3:0] e_stuck;
  bit         in_rst = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_gen(input int ch);
    gp[ch]     = int'($urandom_range(2, 300));
    gh[ch]     = int'($urandom_range(0, gp[ch]));
    gph[ch]    = int'($urandom_range(0, gp[ch] - 1));
    glitch[ch] = int'($urandom_range(0, 2));
    glvl[ch]   = 0;
  endtask

  task automatic set_gen(input int ch, input int p, input int h);
    gp[ch]     = p;
    gh[ch]     = h;
    gph[ch]    = 0;
    glitch[ch] = 0;
    glvl[ch]   = 0;
  endtask

  task automatic set_level(input int ch, input int lvl, input int gl);
    gp[ch]     = 0;
    glvl[ch]   = lvl;
    glitch[ch] = gl;
  endtask

  task automatic drive_inputs();
    logic [3:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      logic b;
      if (gp[ch] == 0) begin
        b = (glvl[ch] != 0);
      end else begin
        b = (gph[ch] < gh[ch]);
        gph[ch] = (gph[ch] + 1) % gp[ch];
      end
      if (glitch[ch] > 0 && int'($urandom_range(0, 99)) < glitch[ch]) b = ~b;
      v[ch] = b;
    end
    pwm_in = v;
  endtask

  // Input level sampled on edge idx; nothing is seen before reset release.
  function automatic int xbit(input int ch, input int idx);
    if (idx < 0) return 0;
    return xh[idx][ch] ? 1 : 0;
  endfunction

  task automatic model_reset();
    n_edge  = 0;
    e_valid = '0;
    e_stuck = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      st[ch]     = M_IDLE;
      r[ch]      = -1;
      e_data[ch] = 0;
      e_per[ch]  = 0;
    end
  endtask

  // The level that is settled during the cycle ending at edge n was sampled
  // two edges earlier. r is the cycle in which the window counters read 1.
  task automatic model_edge();
    int n;
    n = n_edge;
    if (n >= MAXN) begin
      $display("FAIL history: edge %0d, limit %0d", n, MAXN);
      $fatal(1);
    end
    xh[n]   = pwm_in;
    e_valid = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      int s, sp, cnt, hi;
      bit rise, fall;
      s    = xbit(ch, n - 2);
      sp   = xbit(ch, n - 3);
      rise = (s == 1) && (sp == 0);
      fall = (s == 0) && (sp == 1);
      cnt  = n - 1 - r[ch];
      if (cnt > SAT) cnt = SAT;
      if (st[ch] == M_STUCK) begin
        if (rise || fall) begin
          st[ch]      = rise ? M_MEAS : M_IDLE;
          e_stuck[ch] = 1'b0;
          r[ch]       = n - 1;
        end
      end else if (rise) begin
        if (st[ch] == M_MEAS) begin
          hi = 0;
          for (int i = r[ch] - 1; i <= n - 3; i++) hi += xbit(ch, i);
          if (hi > SAT) hi = SAT;
          e_data[ch]  = hi;
          e_per[ch]   = cnt;
          e_valid[ch] = 1'b1;
        end
        st[ch] = M_MEAS;
        r[ch]  = n - 1;
      end else if (cnt == TO) begin
        st[ch]      = M_STUCK;
        e_data[ch]  = (s == 1) ? SAT : 0;
        e_per[ch]   = SAT;
        e_valid[ch] = 1'b1;
        e_stuck[ch] = 1'b1;
      end
    end
    n_edge = n + 1;
  endtask

  task automatic compare_all();
    logic [47:0] ed, ep;
    for (int ch = 0; ch < NCH; ch++) begin
      ed[ch*12 +: 12] = e_data[ch][11:0];
      ep[ch*12 +: 12] = e_per[ch][11:0];
    end
    check("valid", 64'(data_valid), 64'(e_valid));
    check("stuck", 64'(stuck), 64'(e_stuck));
    check("data", 64'({data_channel_3, data_channel_2, data_channel_1, data_channel_0}), 64'(ed));
    check("period", 64'({period_channel_3, period_channel_2, period_channel_1, period_channel_0}), 64'(ep));
  endtask

  task automatic edge_part();
    @(posedge pwm_clk);
    if (!in_rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic step();
    @(negedge pwm_clk);
    drive_inputs();
    edge_part();
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic assert_reset(input int cycles);
    rst    = 1'b1;
    in_rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    run(cycles);
  endtask

  task automatic release_reset();
    @(negedge pwm_clk);
    rst    = 1'b0;
    in_rst = 1'b0;
    drive_inputs();
    edge_part();
  endtask

  initial begin
    int v0, v1, first0, all3, s2, low2, waited;
    for (int ch = 0; ch < NCH; ch++) begin
      gp[ch] = 2; gh[ch] = 1; gph[ch] = ch % 2; glitch[ch] = 30; glvl[ch] = 0;
    end
    #1;
    assert_reset(5);

    // ch0 4095/1000, ch1 held high, ch2 random, ch3 glitches on low.
    set_gen(0, 4095, 1000);
    set_level(1, 1, 0);
    rand_gen(2);
    set_level(3, 0, 2);
    release_reset();
    v0 = 0; v1 = 0; first0 = 0;
    for (int i = 0; i < 3 * 4095 + 100; i++) begin
      step();
      if (data_valid[0]) begin
        v0++;
        if (i < 4000) first0++;
      end
      if (data_valid[1]) v1++;
    end
    check("ch0_first_rise_valids", 64'(first0), 64'd0);
    check("ch0_valid_count", 64'(v0), 64'd3);
    check("ch0_data", 64'(data_channel_0), 64'd1000);
    check("ch0_period", 64'(period_channel_0), 64'd4095);
    check("ch1_stuck_high", 64'(stuck[1]), 64'd1);
    check("ch1_data_high", 64'(data_channel_1), 64'd4095);
    check("ch1_period_high", 64'(period_channel_1), 64'd4095);
    check("ch1_valid_count", 64'(v1), 64'd1);

    // ch1 released low: stuck clears, then re-times-out reporting 0.
    set_level(1, 0, 0);
    run(10);
    check("ch1_stuck_cleared", 64'(stuck[1]), 64'd0);
    run(4200);
    check("ch1_stuck_low", 64'(stuck[1]), 64'd1);
    check("ch1_data_low", 64'(data_channel_1), 64'd0);

    // Four channels in lockstep: duties 1, 2048, 4094 and constant low.
    assert_reset(2);
    set_gen(0, 4095, 1);
    set_gen(1, 4095, 2048);
    set_gen(2, 4095, 4094);
    set_level(3, 0, 0);
    release_reset();
    all3 = 0;
    for (int i = 0; i < 2 * 4095 + 300; i++) begin
      step();
      if (data_valid[2:0] == 3'b111) all3++;
    end
    check("coincident_valids", 64'(all3), 64'd2);
    check("c_data0", 64'(data_channel_0), 64'd1);
    check("c_data1", 64'(data_channel_1), 64'd2048);
    check("c_data2", 64'(data_channel_2), 64'd4094);
    check("c_period0", 64'(period_channel_0), 64'd4095);
    check("c_period2", 64'(period_channel_2), 64'd4095);
    check("c_stuck", 64'(stuck), 64'b1000);
    check("c_data3", 64'(data_channel_3), 64'd0);

    // ch2 period 4096 must time out every period.
    rand_gen(0);
    rand_gen(1);
    set_gen(2, 4096, 10);
    set_level(3, 0, 2);
    s2 = 0; low2 = 0;
    for (int i = 0; i < 3 * 4096 + 200; i++) begin
      step();
      if (stuck[2]) s2++;
      if (data_valid[2] && period_channel_2 < 12'd4095) low2++;
    end
    check("ch2_seen_stuck", 64'(s2 != 0), 64'd1);
    check("ch2_short_periods", 64'(low2), 64'd0);
    set_gen(2, 100, 1);
    run(600);
    check("ch2_data", 64'(data_channel_2), 64'd1);
    check("ch2_period", 64'(period_channel_2), 64'd100);
    check("ch2_stuck", 64'(stuck[2]), 64'd0);

    // Reset pulse in the middle of a ch0 high phase.
    set_gen(0, 500, 200);
    run(1500);
    waited = 0;
    while (gph[0] != 100 && waited < 600) begin
      step();
      waited++;
    end
    check("mid_high_reached", 64'(gph[0]), 64'd100);
    assert_reset(1);
    check("rst_data0", 64'(data_channel_0), 64'd0);
    release_reset();
    run(1600);
    check("post_rst_data0", 64'(data_channel_0), 64'd200);
    check("post_rst_period0", 64'(period_channel_0), 64'd500);

    // Fully random segments, one with a short reset.
    for (int seg = 0; seg < 5; seg++) begin
      for (int ch = 0; ch < NCH; ch++) rand_gen(ch);
      if (seg == 2) begin
        assert_reset(1);
        release_reset();
      end
      run(800);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_pwm_capture_if.md
Name: axi_pwm_capture_if

Overview:
Four-channel PWM capture front-end. It is the receive-side counterpart of the 12-bit PWM generator interface. Each channel synchronizes an external PWM input and measures high time and period in pwm_clk cycles. It presents 12-bit duty words in the same encoding the generator consumes, so a generator driven with word D over a 4095-cycle frame reads back as D. The block sits between FPGA input pins and the AXI register map that samples the captured words.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input (min 2); sets latency.
TIMEOUT, 4095, cycles without a rising edge before a channel is declared stuck (range 2..4095).

Ports:
pwm_clk  input  1  capture clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
pwm_in  input  4  asynchronous PWM inputs; bit N is channel N.
data_channel_0..3  output  12 each  last captured high time, in cycles.
period_channel_0..3  output  12 each  last captured period, in cycles.
data_valid  output  4  one-cycle pulse per channel when its data/period registers update.
stuck  output  4  level; channel had no rising edge within TIMEOUT cycles.

Behaviour:
- Reset (async on rst=1):
  - All outputs are 0.
  - Synchronizer and edge-detect flops are 0.
  - Counters are 0; all channels go to IDLE.
- Per channel, s is the last synchronizer stage and s_d is s delayed by one cycle.
  - rise = s & ~s_d.
  - fall = ~s & s_d.
- Counters (12-bit, saturate at 4095, never wrap):
  - On a rise cycle: period_cnt <= 1 and high_cnt <= 1.
  - Otherwise: period_cnt increments; high_cnt increments only while s=1.
  - A period of P cycles with D high cycles gives period_cnt=P and high_cnt=D at the next rise.
- FSM per channel:
  - IDLE: counters run, no measurement yet.
    - rise -> MEASURE; this first partial period is discarded, no valid.
    - period_cnt==TIMEOUT and no rise -> STUCK.
  - MEASURE:
    - rise -> latch data_channel<=high_cnt and period_channel<=period_cnt, pulse data_valid; stay in MEASURE.
    - period_cnt==TIMEOUT and no rise -> STUCK.
  - STUCK entry:
    - Latch data_channel <= s ? 4095 : 0.
    - Latch period_channel <= 4095.
    - Pulse data_valid once; set stuck=1.
  - STUCK exit:
    - rise -> MEASURE; stuck<=0, counters restart at 1, no valid.
    - fall -> IDLE; stuck<=0, counters restart at 1, no valid.
    - A constant low after a stuck-high channel therefore re-times-out and reports 0.
- Priority: rise beats timeout in the same cycle. With TIMEOUT=4095, a 4095-cycle period is valid and a 4096-cycle period is stuck.
- Latency: data_valid rises SYNC_STAGES+1 pwm_clk edges after the first edge that samples the new input level.
  - With default SYNC_STAGES=2, the edges are sync1, sync2, output register.
  - data_channel and period_channel change on the same edge that data_valid asserts.
  - They hold between updates.
- Outputs between updates: data_valid is 0 and held values are stable.
- Channels are fully independent; simultaneous events on several channels are all honoured in the same cycle.
- Reset mid-period: outputs clear immediately. The first post-reset rise is treated as in IDLE, so no stale measurement is emitted.
- Glitches of 1 cycle at pwm_clk resolution are measured, not filtered.

Test Plan:
- Reset check: hold rst=1 for 5 cycles with toggling inputs -> all data/period 0, data_valid=0, stuck=0. Release rst -> first input rise produces no data_valid.
- ch0 period 4095, high 1000 -> first period discarded. Afterwards data_channel_0=1000 and period_channel_0=4095, with data_valid[0] exactly once per 4095 cycles, 3 edges after the sampled rise.
- ch1 driven high after reset and held -> 4095 cycles after the rise, stuck[1]=1, data_channel_1=4095, period_channel_1=4095, single valid pulse. Drive low -> stuck clears; 4095 cycles later stuck[1]=1 with data_channel_1=0.
- Four channels at once, period 4095 with duties 1, 2048, 4094, and constant low -> 1/4095, 2048/4095 and 4094/4095, with ch3 stuck and reporting 0. Valid pulses are coincident where rises align.
- Period 4096, high 10 on ch2 -> timeout fires, stuck[2]=1, no period_channel_2 value below 4095. Then period 100, high 1 -> after one discarded period, data=1, period=100, stuck=0.
- Assert rst for 1 cycle mid-high on ch0 during a steady 200/500 waveform -> outputs drop to 0 immediately. The first post-reset period is discarded; the next yields data=200 and period=500.
